// File: rtl/ripple_carry_adder_32_pkg.sv
// Shared constants and result type for the 32-bit ripple-carry adder.
package ripple_carry_adder_32_pkg;

  localparam int ADDER_WIDTH = 32;

  typedef struct packed {
    logic                   ovf;
    logic                   cout;
    logic [ADDER_WIDTH-1:0] sum;
  } add_result_t;

endpackage : ripple_carry_adder_32_pkg

// File: rtl/ripple_carry_adder_32_fa_cell.sv
// One-bit full adder: the repeating stage of the ripple-carry chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fa_cell

// File: rtl/ripple_carry_adder_32.sv
// 32-bit ripple-carry adder with combinational result, signed overflow flag,
// and a one-cycle registered copy of all three outputs.
module ripple_carry_adder_32
  import ripple_carry_adder_32_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    fa_cell u_fa (
      .a  (in1[i]),
      .b  (in2[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign ovf  = carry[WIDTH] ^ carry[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule : ripple_carry_adder_32

// File: tb/tb_ripple_carry_adder_32.sv
// Self-checking bench: directed literal vectors, random combinational checks
// with the clock idle, then a clocked random run compared every cycle.
module tb_ripple_carry_adder_32;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        ovf_q;

  int n_cmp = 0;
  int n_bad = 0;

  logic        clk_en  = 1'b0;
  logic        run_chk = 1'b0;
  logic [33:0] exp_reg;   // {ovf, cout, sum} expected in the output registers
  logic [33:0] pending;   // model result of the inputs awaiting the next edge

  ripple_carry_adder_32 dut (
    .clk    (clk),
    .rst    (rst),
    .in1    (in1),
    .in2    (in2),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Reference: exact integer arithmetic; ovf from the signed result range.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    logic [32:0] full;
    longint      s;
    logic        v;
    full = {1'b0, a} + {1'b0, b} + {32'd0, c};
    s    = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    v    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {v, full};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle compare, half a period away from the active edge.
  initial begin
    logic [33:0] m;
    forever begin
      @(negedge clk);
      if (run_chk) begin
        m = model(in1, in2, cin);
        check("comb", {30'd0, ovf, cout, sum}, {30'd0, m});
        check("reg",  {30'd0, ovf_q, cout_q, sum_q}, {30'd0, exp_reg});
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] s;
    logic        co;
    logic        v;
  } vec_t;

  vec_t dir[11] = '{
    '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0},
    '{32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b0, 1'b0},
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 1'b0},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0},
    '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
    '{32'hFF32_0012, 32'hBD30_2991, 1'b0, 32'hBC62_29A3, 1'b1, 1'b0},
    '{32'hFF32_0012, 32'hBD30_2991, 1'b1, 32'hBC62_29A4, 1'b1, 1'b0},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1}
  };

  initial begin
    rst = 1'b1;
    in1 = '0;
    in2 = '0;
    cin = 1'b0;
    #1;
    check("reset_regs", {30'd0, ovf_q, cout_q, sum_q}, 64'd0);

    // Clock idle, reset held: combinational path must still be correct.
    foreach (dir[i]) begin
      in1 = dir[i].a;
      in2 = dir[i].b;
      cin = dir[i].c;
      #2;
      check($sformatf("dir%0d_dut", i), {30'd0, ovf, cout, sum},
            {30'd0, dir[i].v, dir[i].co, dir[i].s});
      check($sformatf("dir%0d_model", i), {30'd0, model(dir[i].a, dir[i].b, dir[i].c)},
            {30'd0, dir[i].v, dir[i].co, dir[i].s});
    end

    for (int i = 0; i < 24; i++) begin
      in1 = rand_operand();
      in2 = rand_operand();
      cin = 1'($urandom_range(0, 1));
      #2;
      check("idle_rand", {30'd0, ovf, cout, sum}, {30'd0, model(in1, in2, cin)});
    end
    check("idle_regs", {30'd0, ovf_q, cout_q, sum_q}, 64'd0);

    // Clocked random run; reset released at the first edge, pulsed mid-stream.
    pending = model(in1, in2, cin);
    exp_reg = '0;
    clk_en  = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      exp_reg = rst ? 34'd0 : pending;
      run_chk = 1'b1;
      if (n == 0 || n == 104) rst = 1'b0;
      in1     = rand_operand();
      in2     = rand_operand();
      cin     = 1'($urandom_range(0, 1));
      pending = model(in1, in2, cin);
      if (n == 100) begin
        #2;
        rst     = 1'b1;
        exp_reg = '0;
      end
    end

    // Directed overflow capture followed by a between-edge reset.
    run_chk = 1'b0;
    @(posedge clk);
    #1;
    in1 = 32'h7FFF_FFFF;
    in2 = 32'h0000_0001;
    cin = 1'b0;
    #2;
    check("ovf_comb", {30'd0, ovf, cout, sum}, {30'd0, 1'b1, 1'b0, 32'h8000_0000});
    @(posedge clk);
    #1;
    check("ovf_sum_q", {32'd0, sum_q}, {32'd0, 32'h8000_0000});
    check("ovf_flags_q", {62'd0, ovf_q, cout_q}, {62'd0, 1'b1, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    check("rst_regs", {30'd0, ovf_q, cout_q, sum_q}, 64'd0);
    check("rst_comb", {30'd0, ovf, cout, sum}, {30'd0, 1'b1, 1'b0, 32'h8000_0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ripple_carry_adder_32

// File: doc/ripple_carry_adder_32.md
Name: ripple_carry_adder_32

Overview:
- 32-bit ripple-carry binary adder: in1 + in2 + cin, producing a 32-bit sum and a carry-out.
- The primary result path is purely combinational and available without any clock edge.
- A registered copy of the result is also provided for pipelined consumers on the single clock domain.
- Used as the leaf integer-add datapath element.

Parameters:
- WIDTH, 32, operand/sum width. Only 32 is required to work; the ripple structure is generated from WIDTH.

Ports:
- clk  input  1  rising-edge clock; drives only the registered outputs.
- rst  input  1  asynchronous, active-high reset; clears the registered outputs only.
- in1  input  32  addend A, unsigned (two's-complement interpretation is used only for ovf).
- in2  input  32  addend B.
- cin  input  1  carry into bit 0.
- sum  output  32  combinational sum bits [31:0].
- cout  output  1  combinational carry out of bit 31.
- ovf  output  1  combinational signed overflow.
- sum_q  output  32  registered sum.
- cout_q  output  1  registered cout.
- ovf_q  output  1  registered ovf.

Behaviour:
- Combinational function: {cout, sum} = in1 + in2 + cin, computed as a 33-bit exact result with no truncation except the split into cout and sum.
- Structure: a chain of 32 one-bit full adders.
  - c[0] = cin.
  - Stage i: s[i] = a ^ b ^ c[i]; c[i+1] = a&b | a&c[i] | b&c[i].
  - cout = c[32].
- ovf = c[32] ^ c[31].
- Combinational outputs have zero clock latency.
  - Settle within one propagation delay of any input change.
  - Independent of clk and rst: they are valid even if clk never toggles or rst is asserted.
  - No X propagation from clk or rst into sum, cout or ovf.
- Registered outputs sum_q, cout_q and ovf_q:
  - Capture sum, cout and ovf on every rising clk edge while rst = 0.
  - Latency is one cycle. There is no enable and no handshake.
- Reset:
  - While rst = 1 (asynchronous assertion), sum_q = 0, cout_q = 0 and ovf_q = 0 immediately.
  - Deassertion takes effect at the next rising clk edge, which captures the current combinational result.
  - Reset asserted mid-stream discards the pending result. The combinational outputs are unaffected.
- Wrap-around:
  - All-ones + 1 gives sum 0 and cout 1.
  - The maximum result is 0xFFFFFFFF + 0xFFFFFFFF + 1, giving sum 0xFFFFFFFF and cout 1.
- No internal state other than the three output registers. No latches.

Decomposition:
- Shared package: constant ADDER_WIDTH = 32.
- Sub-module fa_cell: 1-bit full adder with ports a, b, ci, s, co.
  - Instantiated WIDTH times in a generate loop, with the carry wired stage to stage.
  - The top level adds the ovf logic and the output register block.

Test Plan:
- Check combinational outputs 2 ns after applying inputs, with clk held idle. Separately, with clk running, check registered outputs one cycle later.
- Zero and small operands:
  - 0x00000000 + 0x00000000, cin 0 -> sum 0x00000000, cout 0, ovf 0.
  - 0x00000001 + 0x00000001, cin 1 -> sum 0x00000003, cout 0.
- Full carry ripple:
  - 0xFFFFFFFF + 0x00000001, cin 0 -> sum 0x00000000, cout 1, ovf 0.
  - Same operands with cin 1 -> sum 0x00000001, cout 1.
- Maximum operands:
  - 0xFFFFFFFF + 0xFFFFFFFF, cin 0 -> sum 0xFFFFFFFE, cout 1.
  - Same operands with cin 1 -> sum 0xFFFFFFFF, cout 1.
- Alternating bits and mixed operands:
  - 0xAAAAAAAA + 0x55555555, cin 0 -> sum 0xFFFFFFFF, cout 0.
  - Same operands with cin 1 -> sum 0x00000000, cout 1.
  - 0xFF320012 + 0xBD302991, cin 0 -> sum 0xBC6229A3, cout 1.
  - Same operands with cin 1 -> sum 0xBC6229A4, cout 1.
- Signed overflow and registers:
  - 0x7FFFFFFF + 0x00000001, cin 0 -> sum 0x80000000, cout 0, ovf 1.
  - After the next rising clk edge, sum_q = 0x80000000 and ovf_q = 1.
  - Assert rst between edges -> sum_q, cout_q and ovf_q go to 0 immediately while sum still reads 0x80000000.
